// File: rtl/inv_round_key_store_pkg.sv
// Shared constants for the AES-128 inverse round-key store.
// Holds round count, key width, FSM encoding, Rcon and S-box tables.
package inv_round_key_store_pkg;

    localparam int NR = 10;
    localparam int KW = 128;
    localparam int NK = NR + 1;

    localparam logic [3:0] NR4 = 4'(NR);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY  = ST_EMPTY,
        EXPAND = ST_EXPAND,
        READY  = ST_READY
    } state_t;

    // Rcon for entry i (1..10); the sequencer owns sequencing,
    // this table is the reference it is expected to follow.
    function automatic logic [7:0] rcon_byte(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/inv_round_key_store_if.sv
// Sequencer <-> key store bus: key load, Rcon, expansion control, read.
// master = sequencer side, slave = inv_round_key_store.
interface inv_round_key_store_if;
    import inv_round_key_store_pkg::*;

    logic [KW-1:0] key_in;
    logic [31:0]   key_RC;
    logic          ex_start;
    logic          mux3_sel;
    logic [3:0]    rd_sel;
    logic [KW-1:0] round_key;
    logic          keys_ready;

    modport master (
        output key_in,
        output key_RC,
        output ex_start,
        output mux3_sel,
        output rd_sel,
        input  round_key,
        input  keys_ready
    );

    modport slave (
        input  key_in,
        input  key_RC,
        input  ex_start,
        input  mux3_sel,
        input  rd_sel,
        output round_key,
        output keys_ready
    );

endinterface

// File: rtl/inv_round_key_store_sbox.sv
// Combinational forward AES S-box, one byte.
// Ports: a = input byte, y = substituted byte.
module aes_sbox
    import inv_round_key_store_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/inv_round_key_store.sv
// AES-128 key expansion plus 11-entry round-key buffer read in reverse.
// Ports: clk, reset_n (sync, active-low), bus (slave: key/Rcon/ctl in, key out).
module inv_round_key_store
    import inv_round_key_store_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    inv_round_key_store_if.slave bus
);

    logic [KW-1:0] key_mem [NK];

    state_t        state;
    state_t        state_nx;
    logic [3:0]    wr_idx;
    logic          kr_q;
    logic [KW-1:0] rk_q;

    logic          restart;
    logic          expand_we;
    logic [3:0]    prev_idx;
    logic [3:0]    rd_idx;
    logic [KW-1:0] prev;
    logic [KW-1:0] next_key;
    logic [31:0]   w0;
    logic [31:0]   w1;
    logic [31:0]   w2;
    logic [31:0]   w3;
    logic [31:0]   rot;
    logic [31:0]   sub;
    logic [31:0]   t;
    logic [31:0]   n0;
    logic [31:0]   n1;
    logic [31:0]   n2;
    logic [31:0]   n3;

    // Restart outranks expansion in every state.
    assign restart = bus.ex_start && !bus.mux3_sel;

    always_comb begin
        state_nx  = state;
        expand_we = 1'b0;
        if (restart) begin
            state_nx = EXPAND;
        end else if (bus.ex_start && bus.mux3_sel) begin
            unique case (state)
                EXPAND: begin
                    if (wr_idx <= NR4) begin
                        expand_we = 1'b1;
                        if (wr_idx == NR4) begin
                            state_nx = READY;
                        end
                    end
                end
                default: begin
                    // EMPTY has no entry 0; READY is write-protected.
                    expand_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx <= 4'd0;
        end else if (restart) begin
            wr_idx <= 4'd1;
        end else if (expand_we) begin
            wr_idx <= wr_idx + 4'd1;
        end
    end

    // keys_ready trails the READY state by one cycle; restart drops it at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kr_q <= 1'b0;
        end else if (restart) begin
            kr_q <= 1'b0;
        end else begin
            kr_q <= (state == READY);
        end
    end

    // One schedule step from the previous entry.
    assign prev_idx = wr_idx - 4'd1;
    assign prev     = key_mem[prev_idx];
    assign w0       = prev[127:96];
    assign w1       = prev[95:64];
    assign w2       = prev[63:32];
    assign w3       = prev[31:0];
    assign rot      = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    assign t        = sub ^ bus.key_RC;
    assign n0       = w0 ^ t;
    assign n1       = n0 ^ w1;
    assign n2       = n1 ^ w2;
    assign n3       = n2 ^ w3;
    assign next_key = {n0, n1, n2, n3};

    // Storage is not reset; it is masked by keys_ready on the read side.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (restart) begin
                key_mem[0] <= bus.key_in;
            end else if (expand_we) begin
                key_mem[wr_idx] <= next_key;
            end
        end
    end

    // Reads see the pre-edge contents: no write bypass.
    assign rd_idx = NR4 - bus.rd_sel;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rk_q <= '0;
        end else if (!kr_q || (bus.rd_sel > NR4)) begin
            rk_q <= '0;
        end else begin
            rk_q <= key_mem[rd_idx];
        end
    end

    assign bus.round_key  = rk_q;
    assign bus.keys_ready = kr_q;

endmodule

// File: tb/tb_inv_round_key_store.sv
// Scoreboard bench for inv_round_key_store using FIPS-197 key schedules.
// Stimulus queues expected reads; a monitor pops them one edge later.
module tb_inv_round_key_store;

    logic clk = 1'b0;
    logic reset_n;
    logic rd_issue = 1'b0;
    logic mon_pend;

    always #5 clk = ~clk;

    inv_round_key_store_if bus();

    inv_round_key_store dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [127:0] rk;
        logic         kr;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0]   rc_tab [10];
    logic [127:0] fk [11];
    logic [127:0] k1;
    logic [127:0] k2;
    logic [127:0] k2_last;

    always @(posedge clk) begin
        exp_t e;
        mon_pend = rd_issue;
        #1;
        if (mon_pend) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL underflow: read seen with empty scoreboard");
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus.round_key !== e.rk || bus.keys_ready !== e.kr) begin
                    errors++;
                    $display("FAIL %s: got rk=%h kr=%b want rk=%h kr=%b",
                             e.tag, bus.round_key, bus.keys_ready, e.rk, e.kr);
                end
            end
        end
    end

    task automatic tick(input bit ex, input bit m3, input logic [31:0] rc,
                        input bit rd, input logic [3:0] sel,
                        input logic [127:0] erk, input bit ekr,
                        input string tag);
        @(negedge clk);
        bus.ex_start = ex;
        bus.mux3_sel = m3;
        bus.key_RC   = rc;
        bus.rd_sel   = sel;
        rd_issue     = rd;
        if (rd) begin
            exp_t e;
            e.rk  = erk;
            e.kr  = ekr;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 32'h0, 1'b0, 4'd0, '0, 1'b0, "");
    endtask

    task automatic rd(input logic [3:0] sel, input logic [127:0] erk,
                      input bit ekr, input string tag);
        tick(1'b0, 1'b0, 32'h0, 1'b1, sel, erk, ekr, tag);
    endtask

    task automatic restart(input logic [127:0] key);
        bus.key_in = key;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 4'd0, '0, 1'b0, "");
    endtask

    task automatic expand(input int i);
        logic [31:0] rc;
        rc = (i >= 1 && i <= 10) ? {rc_tab[i-1], 24'h0} : 32'h5a000000;
        tick(1'b1, 1'b1, rc, 1'b0, 4'd0, '0, 1'b0, "");
    endtask

    task automatic full_expand(input logic [127:0] key);
        restart(key);
        for (int i = 1; i <= 10; i++) expand(i);
        idle();
        idle();
    endtask

    initial begin
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        fk = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        k1      = fk[0];
        k2      = 128'h000102030405060708090a0b0c0d0e0f;
        k2_last = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        reset_n      = 1'b0;
        bus.key_in   = '0;
        bus.key_RC   = '0;
        bus.ex_start = 1'b0;
        bus.mux3_sel = 1'b0;
        bus.rd_sel   = 4'd0;

        idle();
        rd(4'd10, '0, 1'b0, "reset_state");
        idle();
        reset_n = 1'b1;

        // Straight expansion of the FIPS key.
        full_expand(k1);
        rd(4'd10, k1, 1'b1, "k1_sel10");
        rd(4'd9, fk[1], 1'b1, "k1_sel9");
        rd(4'd0, fk[10], 1'b1, "k1_sel0");
        rd(4'd10, k1, 1'b1, "toggle_10");
        rd(4'd5, fk[5], 1'b1, "toggle_5");
        rd(4'd1, fk[9], 1'b1, "toggle_1");
        for (int s = 11; s <= 15; s++) rd(4'(s), '0, 1'b1, "sel_oob");
        rd(4'd0, fk[10], 1'b1, "after_oob");

        // Restart while READY: old entry 0 returned, keys_ready drops.
        bus.key_in = k1;
        tick(1'b1, 1'b0, 32'h0, 1'b1, 4'd10, k1, 1'b0, "restart_kr");
        for (int i = 1; i <= 4; i++) expand(i);
        for (int j = 0; j < 3; j++) rd(4'd0, '0, 1'b0, "stall");
        for (int i = 5; i <= 9; i++) expand(i);
        rd(4'd0, '0, 1'b0, "pre_last");
        expand(10);
        idle();
        idle();
        for (int s = 0; s <= 10; s++) rd(4'(s), fk[10-s], 1'b1, "stall_key");

        // Restart with second key; read is not bypassed.
        bus.key_in = k2;
        tick(1'b1, 1'b0, 32'h0, 1'b1, 4'd10, k1, 1'b0, "no_bypass");
        for (int i = 1; i <= 10; i++) expand(i);
        idle();
        idle();
        rd(4'd0, k2_last, 1'b1, "k2_sel0");
        rd(4'd10, k2, 1'b1, "k2_sel10");

        // Twelve expand cycles: the last two must be ignored.
        restart(k2);
        for (int i = 1; i <= 12; i++) expand(i);
        idle();
        idle();
        rd(4'd0, k2_last, 1'b1, "over_expand");
        rd(4'd10, k2, 1'b1, "over_expand10");

        // Restart on the cycle entry 10 would be written.
        restart(k2);
        for (int i = 1; i <= 9; i++) expand(i);
        restart(k1);
        idle();
        idle();
        rd(4'd0, '0, 1'b0, "restart_at_nr");

        // Reset after entry 6, then expand pulses in EMPTY.
        restart(k1);
        for (int i = 1; i <= 6; i++) expand(i);
        rd(4'd10, '0, 1'b0, "reset_mid");
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        for (int i = 7; i <= 10; i++) expand(i);
        idle();
        rd(4'd0, '0, 1'b0, "empty_ignore");
        full_expand(k1);
        rd(4'd0, fk[10], 1'b1, "post_reset_sel0");
        rd(4'd9, fk[1], 1'b1, "post_reset_sel9");

        begin
            int n;
            n = 0;
            idle();
            while (sb.size() != 0 && n < 10) begin
                idle();
                n++;
            end
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d reads never observed, want 0",
                         sb.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
